// File: rtl/hash_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hash_bus_sequencer
// Purpose  : FPGA-side master for the 8-bit hash bus into the BLAKE2 core.
//            Runs one hash job per start pulse:
//              1. three config bytes (nn, ll[7:0], ll[15:8]),
//              2. the message, zero-padded to whole 64-byte blocks,
//              3. waits for the digest and forwards nn digest bytes.
// Ports    : clk, rst_async          clock / async active-high reset
//            start_i, cfg_nn_i,      job launch and configuration
//            cfg_ll_i
//            src_valid_i/src_data_i  local message byte source
//            src_ready_o             byte consumed this cycle
//            data_o, data_ctrl_o     bus to core: {last_block, cfg, valid}
//            hash_i, hash_ctrl_i     bus from core: {dut_ready, hash_valid}
//            dig_valid_o/dig_data_o  captured digest byte stream
//            busy_o, done_o,         job status
//            timeout_o
// Revision : 1.0  initial release
// ============================================================================
module hash_bus_sequencer #(
  parameter int LL_W      = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic            clk,
  input  logic            rst_async,
  input  logic            start_i,
  input  logic [5:0]      cfg_nn_i,
  input  logic [LL_W-1:0] cfg_ll_i,
  input  logic            src_valid_i,
  input  logic [7:0]      src_data_i,
  output logic            src_ready_o,
  output logic [7:0]      data_o,
  output logic [2:0]      data_ctrl_o,
  input  logic [7:0]      hash_i,
  input  logic [1:0]      hash_ctrl_i,
  output logic            dig_valid_o,
  output logic [7:0]      dig_data_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o
);

  localparam int BLK_W = LL_W - 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFG  = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_READ = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           nn_q, nn_d;
  logic [LL_W-1:0]      ll_q, ll_d;
  logic [LL_W-1:0]      msg_cnt_q, msg_cnt_d;
  logic [BLK_W-1:0]     last_blk_q, last_blk_d;
  logic [BLK_W-1:0]     blk_cnt_q, blk_cnt_d;
  // Shared counter: config byte index in CFG, byte-in-block in DATA,
  // digest bytes received in WAIT/READ.
  logic [5:0]           byte_cnt_q, byte_cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  logic [7:0]           data_q, data_d;
  logic [2:0]           ctrl_q, ctrl_d;
  logic                 dig_valid_q, dig_valid_d;
  logic [7:0]           dig_data_q, dig_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;

  logic                 dut_ready;
  logic                 hash_valid;
  logic [15:0]          ll16;
  logic [LL_W-1:0]      ll_m1;
  logic                 unused_ll_m1_lo;
  logic [BLK_W-1:0]     last_blk_start;
  logic [5:0]           nn_start;
  logic                 msg_pending;
  logic                 is_last_blk;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic                 wd_fire;
  logic [7:0]           cfg_byte;

  assign dut_ready   = hash_ctrl_i[1];
  assign hash_valid  = hash_ctrl_i[0];

  // Length field on the bus is always 16 bits; narrower counters zero-extend.
  assign ll16        = 16'(ll_q);

  // Index of the final block: ceil(ll/64)-1, with an empty message still
  // producing one all-padding block.
  assign ll_m1           = cfg_ll_i - LL_W'(1);
  assign unused_ll_m1_lo = ^ll_m1[5:0];
  assign last_blk_start  = (cfg_ll_i == '0) ? '0 : ll_m1[LL_W-1:6];

  assign nn_start    = (cfg_nn_i == 6'd0) ? 6'd32 : cfg_nn_i;
  assign msg_pending = (msg_cnt_q < ll_q);
  assign is_last_blk = (blk_cnt_q == last_blk_q);

  assign wd_inc      = wd_q + TIMEOUT_W'(1);
  // Fires on the cycle the watchdog would reach all-ones.
  assign wd_fire     = &wd_inc;

  always_comb begin
    case (byte_cnt_q)
      6'd0:    cfg_byte = {2'b00, nn_q};
      6'd1:    cfg_byte = ll16[7:0];
      default: cfg_byte = ll16[15:8];
    endcase
  end

  // The consume strobe must coincide with the cycle the byte is taken, so it
  // is decoded from registered state and the live handshake inputs rather
  // than delayed a cycle (a delayed strobe would make the source repeat a
  // byte). It still drops immediately on reset because state_q does.
  assign src_ready_o = (state_q == ST_DATA) && msg_pending && src_valid_i && dut_ready;

  always_comb begin
    state_d     = state_q;
    nn_d        = nn_q;
    ll_d        = ll_q;
    msg_cnt_d   = msg_cnt_q;
    last_blk_d  = last_blk_q;
    blk_cnt_d   = blk_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    wd_d        = wd_q;
    data_d      = data_q;
    ctrl_d      = 3'b000;
    dig_valid_d = 1'b0;
    dig_data_d  = dig_data_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          nn_d       = nn_start;
          ll_d       = cfg_ll_i;
          last_blk_d = last_blk_start;
          msg_cnt_d  = '0;
          blk_cnt_d  = '0;
          byte_cnt_d = 6'd0;
          wd_d       = '0;
          timeout_d  = 1'b0;
          state_d    = ST_CFG;
        end
      end

      ST_CFG: begin
        ctrl_d = 3'b010;
        if (dut_ready) begin
          data_d = cfg_byte;
          ctrl_d = 3'b011;
          if (byte_cnt_q == 6'd2) begin
            byte_cnt_d = 6'd0;
            state_d    = ST_DATA;
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end
      end

      ST_DATA: begin
        ctrl_d = {is_last_blk, 2'b00};
        // Padding bytes need only the core; message bytes also need the source.
        if (dut_ready && (!msg_pending || src_valid_i)) begin
          ctrl_d[0] = 1'b1;
          if (msg_pending) begin
            data_d    = src_data_i;
            msg_cnt_d = msg_cnt_q + LL_W'(1);
          end else begin
            data_d    = 8'h00;
          end
          // 6-bit counter rolls 63 -> 0 at each block boundary.
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (byte_cnt_q == 6'd63) begin
            if (is_last_blk) begin
              wd_d    = '0;
              state_d = ST_WAIT;
            end else begin
              blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
          end
        end
      end

      ST_WAIT, ST_READ: begin
        if (hash_valid) begin
          dig_valid_d = 1'b1;
          dig_data_d  = hash_i;
          wd_d        = '0;
          // In WAIT byte_cnt is 0, so this also covers the first byte.
          byte_cnt_d  = byte_cnt_q + 6'd1;
          if ((byte_cnt_q + 6'd1) == nn_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ;
          end
        end else if (wd_fire) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q     <= ST_IDLE;
      nn_q        <= '0;
      ll_q        <= '0;
      msg_cnt_q   <= '0;
      last_blk_q  <= '0;
      blk_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      wd_q        <= '0;
      data_q      <= '0;
      ctrl_q      <= '0;
      dig_valid_q <= 1'b0;
      dig_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nn_q        <= nn_d;
      ll_q        <= ll_d;
      msg_cnt_q   <= msg_cnt_d;
      last_blk_q  <= last_blk_d;
      blk_cnt_q   <= blk_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      wd_q        <= wd_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      dig_valid_q <= dig_valid_d;
      dig_data_q  <= dig_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign data_o      = data_q;
  assign data_ctrl_o = ctrl_q;
  assign dig_valid_o = dig_valid_q;
  assign dig_data_o  = dig_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_bus_sequencer
// Purpose  : Self-checking bench for hash_bus_sequencer. Each job pushes the
//            expected bus bytes and digest bytes into queues; a negedge
//            monitor pops and compares them as the sequencer emits them.
// Revision : 1.0  initial release
// ============================================================================
module tb_hash_bus_sequencer;
  localparam int LL_W = 16;
  localparam int TW   = 4;

  logic            clk = 1'b0;
  logic            rst_async;
  logic            start_i;
  logic [5:0]      cfg_nn_i;
  logic [LL_W-1:0] cfg_ll_i;
  logic            src_valid_i;
  logic [7:0]      src_data_i;
  logic            src_ready_o;
  logic [7:0]      data_o;
  logic [2:0]      data_ctrl_o;
  logic [7:0]      hash_i;
  logic [1:0]      hash_ctrl_i;
  logic            dig_valid_o;
  logic [7:0]      dig_data_o;
  logic            busy_o;
  logic            done_o;
  logic            timeout_o;

  logic            rdy;
  logic            hvalid;
  assign hash_ctrl_i = {rdy, hvalid};

  hash_bus_sequencer #(.LL_W(LL_W), .TIMEOUT_W(TW)) dut (
    .clk         (clk),
    .rst_async   (rst_async),
    .start_i     (start_i),
    .cfg_nn_i    (cfg_nn_i),
    .cfg_ll_i    (cfg_ll_i),
    .src_valid_i (src_valid_i),
    .src_data_i  (src_data_i),
    .src_ready_o (src_ready_o),
    .data_o      (data_o),
    .data_ctrl_o (data_ctrl_o),
    .hash_i      (hash_i),
    .hash_ctrl_i (hash_ctrl_i),
    .dig_valid_o (dig_valid_o),
    .dig_data_o  (dig_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [7:0] hbyte(input int k);
    return 8'(k * 29 + 3);
  endfunction

  // Scoreboard: {last_block, cfg, data} per bus byte, and digest bytes.
  logic [9:0] exp_bus[$];
  logic [7:0] exp_dig[$];

  int cyc          = 0;
  int hs_cnt       = 0;
  int bus_seen     = 0;
  int last_bus_cyc = 0;
  int done_cnt     = 0;
  int done_cyc     = 0;

  always @(negedge clk) begin
    cyc++;
    if (data_ctrl_o[0]) begin
      if (exp_bus.size() == 0) begin
        check("bus_extra", int'({data_ctrl_o[2:1], data_o}), -1);
      end else begin
        check("bus", int'({data_ctrl_o[2:1], data_o}), int'(exp_bus.pop_front()));
        bus_seen++;
        last_bus_cyc = cyc;
      end
    end
    if (dig_valid_o) begin
      if (exp_dig.size() == 0) check("dig_extra", int'(dig_data_o), -1);
      else                     check("dig", int'(dig_data_o), int'(exp_dig.pop_front()));
    end
    if (src_valid_i && src_ready_o) hs_cnt++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Entered and left at posedge+1. rdy_mode: 0 always ready, 1 toggle,
  // 2 random. gap: percent of cycles the source withholds a byte.
  task automatic run_job(input int ll, input int nn_in, input int rdy_mode, input int gap,
                         input bit give_hash, input int abort_at);
    int nn, nblk, total, src_idx, hidx, hdly;
    bit finished;
    logic [7:0] msg[$];
    logic [7:0] b;
    nn   = (nn_in == 0) ? 32 : nn_in;
    nblk = (ll == 0) ? 1 : (ll + 63) / 64;
    total = 3 + nblk * 64;
    for (int i = 0; i < ll; i++) msg.push_back(8'(97 + i));
    exp_bus.delete();
    exp_dig.delete();
    exp_bus.push_back({2'b01, 8'(nn)});
    exp_bus.push_back({2'b01, 8'(ll)});
    exp_bus.push_back({2'b01, 8'(ll >> 8)});
    for (int i = 0; i < nblk * 64; i++) begin
      if (i < ll) b = msg[i];
      else        b = 8'h00;
      exp_bus.push_back({(i / 64 == nblk - 1), 1'b0, b});
    end
    if (give_hash) for (int k = 0; k < nn; k++) exp_dig.push_back(hbyte(k));
    hs_cnt = 0; bus_seen = 0; done_cnt = 0; last_bus_cyc = 0; done_cyc = 0;

    cfg_nn_i = 6'(nn_in);
    cfg_ll_i = LL_W'(ll);
    start_i  = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    check("busy_after_start", int'(busy_o), 1);
    check("timeout_cleared", int'(timeout_o), 0);
    @(posedge clk); #1;

    src_idx = 0; hidx = 0; hdly = 0; finished = 1'b0;
    for (int c = 0; c < 200 + total * 4 && !finished; c++) begin
      if (abort_at >= 0 && bus_seen >= 3 + abort_at) begin
        #2 rst_async = 1'b1;
        #1;
        check("rst_ctrl",  int'(data_ctrl_o), 0);
        check("rst_ready", int'(src_ready_o), 0);
        check("rst_busy",  int'(busy_o), 0);
        check("rst_data",  int'(data_o), 0);
        exp_bus.delete();
        exp_dig.delete();
        @(posedge clk); #1 rst_async = 1'b0; src_valid_i = 1'b0;
        @(negedge clk);
        check("rst_no_done", done_cnt, 0);
        @(posedge clk); #1;
        return;
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = c[0];
        default: rdy = 1'($urandom_range(1));
      endcase
      if (src_idx < ll) begin
        src_valid_i = ($urandom_range(99) >= gap);
        src_data_i  = msg[src_idx];
      end else begin
        src_valid_i = 1'b1;
        src_data_i  = 8'hEE;
      end
      hvalid = 1'b0;
      if (give_hash && bus_seen == total) begin
        hdly++;
        if (hdly > 3 && (hdly % 3) != 0) begin
          hvalid = 1'b1;
          hash_i = hbyte(hidx);
          hidx++;
        end
      end
      @(negedge clk);
      if (src_valid_i && src_ready_o) src_idx++;
      if (done_o) finished = 1'b1;
      @(posedge clk); #1;
    end

    // Extra digest bytes after completion must be ignored.
    src_valid_i = 1'b0;
    hvalid = 1'b1;
    hash_i = 8'h5A;
    repeat (3) @(posedge clk);
    #1 hvalid = 1'b0;
    check("done_pulses", done_cnt, 1);
    check("src_handshakes", hs_cnt, ll);
    check("bus_remaining", exp_bus.size(), 0);
    check("dig_remaining", exp_dig.size(), 0);
    check("busy_end", int'(busy_o), 0);
    if (give_hash) begin
      check("timeout_flag", int'(timeout_o), 0);
    end else begin
      check("timeout_flag", int'(timeout_o), 1);
      check("timeout_latency", done_cyc - last_bus_cyc, (1 << TW) - 1);
    end
  endtask

  initial begin
    rst_async = 1'b1;
    start_i = 1'b0; cfg_nn_i = '0; cfg_ll_i = '0;
    src_valid_i = 1'b0; src_data_i = '0;
    hash_i = '0; rdy = 1'b1; hvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl",      int'(data_ctrl_o), 0);
    check("reset_data",      int'(data_o), 0);
    check("reset_ready",     int'(src_ready_o), 0);
    check("reset_dig_valid", int'(dig_valid_o), 0);
    check("reset_dig_data",  int'(dig_data_o), 0);
    check("reset_busy",      int'(busy_o), 0);
    check("reset_done",      int'(done_o), 0);
    check("reset_timeout",   int'(timeout_o), 0);
    @(posedge clk); #1 rst_async = 1'b0;
    @(posedge clk); #1;

    run_job(3,   32, 0, 0,  1'b1, -1);   // "abc"
    run_job(0,   0,  0, 0,  1'b1, -1);   // empty message, nn=0 -> 32
    run_job(128, 20, 0, 0,  1'b1, -1);   // exactly two blocks
    run_job(70,  1,  1, 30, 1'b1, -1);   // toggling ready, source gaps
    run_job(200, 7,  2, 50, 1'b1, -1);   // random ready, heavy gaps
    run_job(5,   8,  0, 0,  1'b0, -1);   // no digest -> watchdog
    run_job(9,   4,  1, 0,  1'b1, -1);   // timeout flag cleared by start
    run_job(100, 16, 0, 0,  1'b1, 30);   // reset in DATA byte 30
    run_job(3,   32, 0, 0,  1'b1, -1);   // clean job after reset

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
